serial_pattern_tx: RTL and testbench

Serial pattern transmitter: accepts a W-bit word over a valid/ready handshake and serialises it MSB-first onto a 1-bit stream `a`, optionally repeating it with idle gaps between copies. It is the stimulus source for the team's serial sequence detector FSMs. It drives their `a` input directly, and `a_valid` qualifies each bit. The block is a small FSM with a shift register, a bit counter, a repeat counter and a gap counter.

---
 rtl/serial_pattern_tx.sv | 190 +++++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
// Serialises a W-bit word MSB-first onto a 1-bit stream (a / a_valid / a_last).
// The word is sent in_repeat+1 times, with GAP_CYCLES idle cycles between copies.
// Optional feature macro: SERIAL_PATTERN_TX_PARITY_EN.
// When it is defined, every copy carries one extra even-parity bit.
// a_last then moves to that parity bit.
//
// Outputs are registered and always describe the current cycle.
// The state register therefore reads "what the block is doing this cycle".
// The first bit is loaded on the handshake edge, which gives one cycle of latency.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | no job; in_ready = 1, a/a_valid/a_last = 0
// S_SHIFT  | a carries data bit cnt_q of the current copy
// S_GAP    | idle gap between copies; gap_q counts down remaining gap cycles
// S_PARITY | a carries the parity bit of the current copy (parity build only)

module serial_pattern_tx #(
   parameter int W          = 6,
   parameter int GAP_CYCLES = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic [3:0]   in_repeat,
   output logic         a,
   output logic         a_valid,
   output logic         a_last
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHIFT  = 2'd1;
   localparam logic [1:0] S_GAP    = 2'd2;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
   localparam logic [1:0] S_PARITY = 2'd3;
`endif

   // The bit counter indexes the bit currently on a (0..W-1). W >= 2 keeps CW >= 1.
   localparam int              CW       = $clog2(W);
   localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);
`ifndef SERIAL_PATTERN_TX_PARITY_EN
   localparam logic [CW-1:0]   CNT_PEN  = CW'(W - 2);
`endif
   // The gap counter is loaded with GAP_CYCLES-1 and leaves GAP when it reaches 0.
   localparam logic [3:0]      GAP_LOAD = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  word_q,  word_d;
   logic [W-1:0]  shreg_q, shreg_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [3:0]    rep_q,   rep_d;
   logic [3:0]    gap_q,   gap_d;
   logic          a_q,       a_d;
   logic          a_valid_q, a_valid_d;
   logic          a_last_q,  a_last_d;

   logic          copy_done;
   logic          start_copy;

   assign in_ready = (state_q == S_IDLE);
   assign a        = a_q;
   assign a_valid  = a_valid_q;
   assign a_last   = a_last_q;

   // Next-state and next-output logic.
   // Outputs default to idle (0) and are driven only for the cycle they describe.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      rep_d      = rep_q;
      gap_d      = gap_q;
      a_d        = 1'b0;
      a_valid_d  = 1'b0;
      a_last_d   = 1'b0;
      copy_done  = 1'b0;
      start_copy = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               word_d    = in_data;
               rep_d     = in_repeat;
               cnt_d     = '0;
               shreg_d   = in_data << 1;
               a_d       = in_data[W-1];
               a_valid_d = 1'b1;
               state_d   = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (cnt_q != CNT_LAST) begin
               a_d       = shreg_q[W-1];
               a_valid_d = 1'b1;
               shreg_d   = shreg_q << 1;
               cnt_d     = cnt_q + 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
               a_last_d  = 1'b0;
`else
               // The last data bit of the final copy ends the job.
               a_last_d  = (cnt_q == CNT_PEN) && (rep_q == 4'd0);
`endif
            end else begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
               a_d       = ^word_q;
               a_valid_d = 1'b1;
               a_last_d  = (rep_q == 4'd0);
               state_d   = S_PARITY;
`else
               copy_done = 1'b1;
`endif
            end
         end

         S_GAP: begin
            if (gap_q == 4'd0) begin
               start_copy = 1'b1;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
         S_PARITY: begin
            copy_done = 1'b1;
         end
`endif

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // End of a copy: either finish the job, or queue another copy after an optional gap.
      if (copy_done) begin
         if (rep_q == 4'd0) begin
            state_d = S_IDLE;
         end else begin
            rep_d = rep_q - 4'd1;
            if (GAP_CYCLES > 0) begin
               state_d = S_GAP;
               gap_d   = GAP_LOAD;
            end else begin
               start_copy = 1'b1;
            end
         end
      end

      // Start a new copy from the captured word. It runs without a bubble when there is no gap.
      if (start_copy) begin
         state_d   = S_SHIFT;
         cnt_d     = '0;
         shreg_d   = word_q << 1;
         a_d       = word_q[W-1];
         a_valid_d = 1'b1;
      end
   end

   // State and output registers.
   // Synchronous reset aborts any job and silences the outputs on the next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         word_q    <= '0;
         shreg_q   <= '0;
         cnt_q     <= '0;
         rep_q     <= '0;
         gap_q     <= '0;
         a_q       <= 1'b0;
         a_valid_q <= 1'b0;
         a_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         rep_q     <= rep_d;
         gap_q     <= gap_d;
         a_q       <= a_d;
         a_valid_q <= a_valid_d;
         a_last_q  <= a_last_d;
      end
   end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed testbench for serial_pattern_tx.
// u0 is built with GAP_CYCLES=0 and u1 with GAP_CYCLES=2; both instances share the inputs.
// Cycle 0 is the handshake cycle, and outputs are sampled at the falling edge.
module tb_serial_pattern_tx;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int W = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [5:0] in_data;
   logic [3:0] in_repeat;
   logic       rdy0, a0, av0, al0;
   logic       rdy1, a1, av1, al1;

   int tests_run    = 0;
   int tests_failed = 0;

   // Captured and expected per-cycle values, indexed by cycle number.
   logic cv0 [0:63], ca0 [0:63], cl0 [0:63], cr0 [0:63];
   logic cv1 [0:63], ca1 [0:63], cl1 [0:63], cr1 [0:63];
   logic ev  [0:63], ea  [0:63], el  [0:63], er  [0:63];

   always #5 clk = ~clk;

   serial_pattern_tx #(.W(W), .GAP_CYCLES(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
      .in_data(in_data), .in_repeat(in_repeat),
      .a(a0), .a_valid(av0), .a_last(al0));

   serial_pattern_tx #(.W(W), .GAP_CYCLES(2)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
      .in_data(in_data), .in_repeat(in_repeat),
      .a(a1), .a_valid(av1), .a_last(al1));

   task automatic clear_exp();
      for (int i = 0; i < 64; i++) begin
         ev[i] = 1'b0; ea[i] = 1'b0; el[i] = 1'b0; er[i] = 1'b1;
      end
   endtask

   // Expected-stream model: a job's copies, optional parity bit and gap cycles, starting at cycle idx.
   task automatic add_job(input logic [5:0] d, input int r, input int g, inout int idx);
      for (int c = 0; c <= r; c++) begin
         for (int b = W - 1; b >= 0; b--) begin
            ev[idx] = 1'b1; ea[idx] = d[b]; el[idx] = 1'b0; er[idx] = 1'b0;
            idx++;
         end
         if (P == 1) begin
            ev[idx] = 1'b1; ea[idx] = ^d; el[idx] = 1'b0; er[idx] = 1'b0;
            idx++;
         end
         el[idx-1] = (c == r);
         if (c < r) begin
            for (int k = 0; k < g; k++) begin
               er[idx] = 1'b0;
               idx++;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_repeat = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Called at the start of cycle 0; returns at the start of cycle 1.
   task automatic start_job(input logic [5:0] d, input logic [3:0] r, input bit hold);
      in_data = d; in_repeat = r; in_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
   endtask

   // Records cycles 1..n from both instances; returns at the start of cycle n+1.
   task automatic capture(input int n);
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         cv0[i] = av0; ca0[i] = a0; cl0[i] = al0; cr0[i] = rdy0;
         cv1[i] = av1; ca1[i] = a1; cl1[i] = al1; cr1[i] = rdy1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      tests_run++;
      if ({a0, av0, al0, rdy0} !== 4'b0001) begin
         tests_failed++;
         $display("FAIL reset_u0 {a,valid,last,ready} got %b exp 0001", {a0, av0, al0, rdy0});
      end
      tests_run++;
      if ({a1, av1, al1, rdy1} !== 4'b0001) begin
         tests_failed++;
         $display("FAIL reset_u1 {a,valid,last,ready} got %b exp 0001", {a1, av1, al1, rdy1});
      end
   endtask

   task automatic test_single();
      int idx = 1;
      do_reset();
      clear_exp();
      add_job(6'b110011, 0, 0, idx);
      start_job(6'b110011, 4'd0, 1'b0);
      capture(W + P + 2);
      for (int i = 1; i <= W + P + 2; i++) begin
         tests_run++;
         if ({cv0[i], ca0[i], cl0[i], cr0[i]} !== {ev[i], ea[i], el[i], er[i]}) begin
            tests_failed++;
            $display("FAIL single cyc%0d {valid,a,last,ready} got %b exp %b", i,
                     {cv0[i], ca0[i], cl0[i], cr0[i]}, {ev[i], ea[i], el[i], er[i]});
         end
      end
   endtask

   task automatic test_repeat_gap();
      int idx = 1;
      int n;
      do_reset();
      clear_exp();
      add_job(6'b101010, 2, 2, idx);
      n = idx + 1;
      start_job(6'b101010, 4'd2, 1'b0);
      capture(n);
      for (int i = 1; i <= n; i++) begin
         tests_run++;
         if ({cv1[i], ca1[i], cl1[i], cr1[i]} !== {ev[i], ea[i], el[i], er[i]}) begin
            tests_failed++;
            $display("FAIL repeat_gap cyc%0d {valid,a,last,ready} got %b exp %b", i,
                     {cv1[i], ca1[i], cl1[i], cr1[i]}, {ev[i], ea[i], el[i], er[i]});
         end
      end
   endtask

   task automatic test_back_to_back();
      int idx = 1;
      int n;
      int hits = 0;
      int nbits = 0;
      logic [5:0] win = '0;
      do_reset();
      clear_exp();
      add_job(6'b110011, 1, 0, idx);
      n = idx + 1;
      start_job(6'b110011, 4'd1, 1'b0);
      // Post-handshake input changes must not reach the running job.
      in_data = 6'b000000; in_repeat = 4'hF;
      capture(n);
      for (int i = 1; i <= n; i++) begin
         tests_run++;
         if ({cv0[i], ca0[i], cl0[i], cr0[i]} !== {ev[i], ea[i], el[i], er[i]}) begin
            tests_failed++;
            $display("FAIL back_to_back cyc%0d {valid,a,last,ready} got %b exp %b", i,
                     {cv0[i], ca0[i], cl0[i], cr0[i]}, {ev[i], ea[i], el[i], er[i]});
         end
         if (cv0[i] === 1'b1) begin
            win = {win[4:0], ca0[i]};
            nbits++;
            if (nbits >= 6 && win == 6'b110011) hits++;
         end
      end
      tests_run++;
      if (hits !== 2) begin
         tests_failed++;
         $display("FAIL back_to_back_detector hits got %0d exp 2", hits);
      end
   endtask

   task automatic test_busy_ignore();
      int idx = 1;
      int n;
      do_reset();
      clear_exp();
      add_job(6'b110011, 0, 0, idx);
      idx++;
      add_job(6'b000111, 0, 0, idx);
      n = idx - 1;
      start_job(6'b110011, 4'd0, 1'b1);
      in_data = 6'b000111;
      capture(n);
      in_valid = 1'b0;
      for (int i = 1; i <= n; i++) begin
         tests_run++;
         if ({cv0[i], ca0[i], cl0[i], cr0[i]} !== {ev[i], ea[i], el[i], er[i]}) begin
            tests_failed++;
            $display("FAIL busy_ignore cyc%0d {valid,a,last,ready} got %b exp %b", i,
                     {cv0[i], ca0[i], cl0[i], cr0[i]}, {ev[i], ea[i], el[i], er[i]});
         end
      end
   endtask

   task automatic test_reset_mid_job();
      int idx = 1;
      do_reset();
      clear_exp();
      add_job(6'b110011, 0, 0, idx);
      start_job(6'b110011, 4'd0, 1'b0);
      capture(2);
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({av0, a0, al0} !== {ev[3], ea[3], el[3]}) begin
         tests_failed++;
         $display("FAIL reset_mid_cyc3 {valid,a,last} got %b exp %b", {av0, a0, al0},
                  {ev[3], ea[3], el[3]});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({a0, av0, al0, rdy0} !== 4'b0001) begin
         tests_failed++;
         $display("FAIL reset_mid_cyc4 {a,valid,last,ready} got %b exp 0001", {a0, av0, al0, rdy0});
      end
      @(posedge clk); #1;
      clear_exp();
      idx = 1;
      add_job(6'b101101, 0, 0, idx);
      start_job(6'b101101, 4'd0, 1'b0);
      capture(W + P + 1);
      for (int i = 1; i <= W + P + 1; i++) begin
         tests_run++;
         if ({cv0[i], ca0[i], cl0[i], cr0[i]} !== {ev[i], ea[i], el[i], er[i]}) begin
            tests_failed++;
            $display("FAIL reset_mid_newjob cyc%0d {valid,a,last,ready} got %b exp %b", i,
                     {cv0[i], ca0[i], cl0[i], cr0[i]}, {ev[i], ea[i], el[i], er[i]});
         end
      end
   endtask

`ifdef SERIAL_PATTERN_TX_PARITY_EN
   task automatic test_parity();
      do_reset();
      start_job(6'b110011, 4'd0, 1'b0);
      capture(8);
      tests_run++;
      if ({cv0[7], ca0[7], cl0[7]} !== 3'b101) begin
         tests_failed++;
         $display("FAIL parity_word1 {valid,a,last} got %b exp 101", {cv0[7], ca0[7], cl0[7]});
      end
      start_job(6'b100000, 4'd0, 1'b0);
      capture(8);
      tests_run++;
      if ({cv0[7], ca0[7], cl0[7]} !== 3'b111) begin
         tests_failed++;
         $display("FAIL parity_word2 {valid,a,last} got %b exp 111", {cv0[7], ca0[7], cl0[7]});
      end
   endtask
`endif

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_repeat = '0;
      test_reset();
      test_single();
      test_repeat_gap();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid_job();
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
